// File: rtl/msk_mixcol_pkg.sv
// Shared definitions for the masked byte-serial forward MixColumns unit.
//   AES_POLY : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   state_t  : controller states (LOAD collects a column, EMIT streams it out)
//   xt()     : multiply a single (unmasked) share byte by x in GF(2^8)
package msk_mixcol_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  // xtime is GF(2)-linear, so applying it to each share separately keeps
  // the sharing intact without ever combining shares.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/msk_mixcol_byte.sv
// One output row of forward MixColumns on d-share masked bytes.
//   x0..x3 : d-share bytes, bit-major (bit i, share j at index i*d+j)
//   y      : 2*x0 ^ 3*x1 ^ x2 ^ x3, same layout
// Purely combinational; share j of y depends only on share j of x0..x3.
module msk_mixcol_byte
  import msk_mixcol_pkg::*;
#(
  parameter int d = 2
) (
  (* fv_type = "sharing", fv_latency = 0, fv_count = 8 *)
  input  logic [8*d-1:0] x0,
  (* fv_type = "sharing", fv_latency = 0, fv_count = 8 *)
  input  logic [8*d-1:0] x1,
  (* fv_type = "sharing", fv_latency = 0, fv_count = 8 *)
  input  logic [8*d-1:0] x2,
  (* fv_type = "sharing", fv_latency = 0, fv_count = 8 *)
  input  logic [8*d-1:0] x3,
  (* fv_type = "sharing", fv_latency = 0, fv_count = 8 *)
  output logic [8*d-1:0] y
);

  for (genvar gi = 0; gi < d; gi++) begin : g_share
    // Gather share gi of each input byte into a plain byte.
    logic [7:0] b0, b1, b2, b3, r;

    for (genvar bi = 0; bi < 8; bi++) begin : g_bit
      assign b0[bi]       = x0[bi*d+gi];
      assign b1[bi]       = x1[bi*d+gi];
      assign b2[bi]       = x2[bi*d+gi];
      assign b3[bi]       = x3[bi*d+gi];
      assign y[bi*d+gi]   = r[bi];
    end

    // 3*x1 expands to xt(x1) ^ x1.
    assign r = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
  end

endmodule

// File: rtl/msk_mixcol_serial.sv
// Masked forward AES MixColumns, byte-serial.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : input handshake, one column byte (rows 0..3) each
//   sh_in               : d-share input byte, bit-major layout
//   out_valid/out_ready : output handshake, one result byte (rows 0..3) each
//   sh_out              : d-share output byte, bit-major layout
//   out_last            : marks row 3 of the output column
// A column is loaded completely, then emitted completely; the two phases
// never overlap. All shares travel through the same linear datapath.
module msk_mixcol_serial
  import msk_mixcol_pkg::*;
#(
  parameter int d = 2
) (
  (* fv_type = "clock" *)
  input  logic           clk,
  (* fv_type = "control" *)
  input  logic           rst,
  (* fv_type = "control" *)
  input  logic           in_valid,
  (* fv_type = "control" *)
  output logic           in_ready,
  (* fv_type = "sharing", fv_latency = 0, fv_count = 8 *)
  input  logic [8*d-1:0] sh_in,
  (* fv_type = "control" *)
  output logic           out_valid,
  (* fv_type = "control" *)
  input  logic           out_ready,
  (* fv_type = "sharing", fv_latency = 0, fv_count = 8 *)
  output logic [8*d-1:0] sh_out,
  (* fv_type = "control" *)
  output logic           out_last
);

  state_t         state_reg, state_next;
  logic [1:0]     cnt_reg, cnt_next;
  logic [8*d-1:0] a_reg [4];
  logic [8*d-1:0] row_out;
  logic           load_en;

  assign load_en = in_valid & in_ready;

  // State and row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Column register, written share-wise in the input layout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        a_reg[i] <= '0;
      end
    end else if (load_en) begin
      a_reg[cnt_reg] <= sh_in;
    end
  end

  // Next-state and handshake decode. in_ready is also held low while rst
  // is asserted so nothing is accepted during reset; otherwise all outputs
  // come from registered state only.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = ~rst;
        if (in_valid) begin
          if (cnt_reg == 2'd3) begin
            state_next = EMIT;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (cnt_reg == 2'd3);
        if (out_ready) begin
          if (cnt_reg == 2'd3) begin
            state_next = LOAD;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = LOAD;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // Row k uses a_k, a_{k+1}, a_{k+2}, a_{k+3}; the 2-bit sums wrap mod 4.
  msk_mixcol_byte #(
    .d (d)
  ) u_byte (
    .x0 (a_reg[cnt_reg]),
    .x1 (a_reg[cnt_reg + 2'd1]),
    .x2 (a_reg[cnt_reg + 2'd2]),
    .x3 (a_reg[cnt_reg + 2'd3]),
    .y  (row_out)
  );

  // Zero outside EMIT so a half-loaded column is never visible.
  assign sh_out = (state_reg == EMIT) ? row_out : '0;

endmodule

// File: tb/tb_msk_mixcol_serial.sv
// Self-checking bench for msk_mixcol_serial (d=2 and d=3 instances).
module tb_msk_mixcol_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [15:0] sh_in2, sh_out2;
  logic        in_valid3, in_ready3, out_valid3, out_ready3, out_last3;
  logic [23:0] sh_in3, sh_out3;

  msk_mixcol_serial #(.d(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .sh_in(sh_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .sh_out(sh_out2),
    .out_last(out_last2)
  );

  msk_mixcol_serial #(.d(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .sh_in(sh_in3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sh_out(sh_out3),
    .out_last(out_last3)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int sel = 0;          // 0 drives the d=2 instance, 1 the d=3 instance
  int first_acc;        // cycle of the row-0 accept of the latest column

  logic [7:0]  col_v [4];
  logic [7:0]  exp_v [4];
  int          gap_v [4];
  int          stall_v [4];
  logic        chk_const;   // compare recombined output with exp_v

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic int nsh();
    return (sel != 0) ? 3 : 2;
  endfunction

  function automatic logic [7:0] share_of(input logic [23:0] v, input int j);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i*nsh()+j];
    return r;
  endfunction

  function automatic logic [7:0] recomb(input logic [23:0] v);
    logic [7:0] r = 8'h00;
    for (int j = 0; j < nsh(); j++) r = r ^ share_of(v, j);
    return r;
  endfunction

  // Random sharing of one byte: all shares but the last random.
  function automatic logic [23:0] make_shares(input logic [7:0] value);
    logic [23:0] v = '0;
    logic [7:0]  acc = value;
    logic [7:0]  s;
    for (int j = 0; j < nsh(); j++) begin
      s = (j == nsh() - 1) ? acc : 8'($urandom);
      acc = acc ^ s;
      for (int i = 0; i < 8; i++) v[i*nsh()+j] = s[i];
    end
    return v;
  endfunction

  // MixColumns matrix row k applied to each share column on its own.
  task automatic model(input logic [23:0] w [4], output logic [23:0] e [4]);
    logic [7:0] c [4];
    logic [7:0] o;
    for (int k = 0; k < 4; k++) e[k] = '0;
    for (int j = 0; j < nsh(); j++) begin
      for (int k = 0; k < 4; k++) c[k] = share_of(w[k], j);
      for (int k = 0; k < 4; k++) begin
        o = gmul(c[k], 8'd2) ^ gmul(c[(k+1)%4], 8'd3) ^ c[(k+2)%4] ^ c[(k+3)%4];
        for (int i = 0; i < 8; i++) e[k][i*nsh()+j] = o[i];
      end
    end
  endtask

  // ---------------- DUT access ----------------
  function automatic logic cur_in_ready();  return (sel != 0) ? in_ready3  : in_ready2;  endfunction
  function automatic logic cur_out_valid(); return (sel != 0) ? out_valid3 : out_valid2; endfunction
  function automatic logic cur_out_last();  return (sel != 0) ? out_last3  : out_last2;  endfunction
  function automatic logic [23:0] cur_sh_out();
    return (sel != 0) ? sh_out3 : {8'h00, sh_out2};
  endfunction

  task automatic set_in(input logic v, input logic [23:0] data);
    if (sel != 0) begin in_valid3 = v; sh_in3 = data; end
    else begin in_valid2 = v; sh_in2 = data[15:0]; end
  endtask

  task automatic set_ready(input logic r);
    if (sel != 0) out_ready3 = r; else out_ready2 = r;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $display("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- column transaction ----------------
  task automatic run_col(input string name);
    logic [23:0] w [4];
    logic [23:0] e [4];
    logic [23:0] snap;
    int t;
    for (int k = 0; k < 4; k++) w[k] = make_shares(col_v[k]);
    model(w, e);
    // load phase
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap_v[k]; g++) begin
        set_in(1'b0, '0);
        step();
        chk({name, "_gap_in_ready"}, 24'(cur_in_ready()), 24'd1);
        chk({name, "_gap_out_valid"}, 24'(cur_out_valid()), 24'd0);
      end
      set_in(1'b1, w[k]);
      t = 0;
      while (!cur_in_ready() && t < 40) begin step(); t++; end
      chk({name, "_in_ready_wait"}, 24'(cur_in_ready()), 24'd1);
      step();
      if (k == 0) first_acc = cyc;
      set_in(1'b0, '0);
    end
    chk({name, "_latency_out_valid"}, 24'(cur_out_valid()), 24'd1);
    // emit phase; a junk input is offered to prove it is stalled
    for (int k = 0; k < 4; k++) begin
      set_in((k < 3) ? 1'b1 : 1'b0, 24'($urandom));
      for (int s = 0; s < stall_v[k]; s++) begin
        set_ready(1'b0);
        snap = cur_sh_out();
        step();
        chk({name, "_stall_stable"}, cur_sh_out(), snap);
        chk({name, "_stall_in_ready"}, 24'(cur_in_ready()), 24'd0);
      end
      set_ready(1'b1);
      chk({name, "_out_valid"}, 24'(cur_out_valid()), 24'd1);
      chk({name, "_emit_in_ready"}, 24'(cur_in_ready()), 24'd0);
      chk({name, "_out_last"}, 24'(cur_out_last()), 24'(k == 3));
      chk({name, "_sh_out"}, cur_sh_out(), e[k]);
      if (chk_const) chk({name, "_unmasked"}, 24'(recomb(cur_sh_out())), 24'(exp_v[k]));
      $display("%s row%0d: sh_out=%h unmasked=%h", name, k, cur_sh_out(), recomb(cur_sh_out()));
      step();
      set_ready(1'b0);
    end
    set_in(1'b0, '0);
    chk({name, "_done_out_valid"}, 24'(cur_out_valid()), 24'd0);
    chk({name, "_done_in_ready"}, 24'(cur_in_ready()), 24'd1);
  endtask

  task automatic set_col(input logic [31:0] c, input logic [31:0] x);
    for (int k = 0; k < 4; k++) begin
      col_v[k] = c[31-8*k -: 8];
      exp_v[k] = x[31-8*k -: 8];
      gap_v[k] = 0;
      stall_v[k] = 0;
    end
    chk_const = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c1;
    rst = 1'b1;
    in_valid2 = 1'b0; out_ready2 = 1'b0; sh_in2 = '0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; sh_in3 = '0;
    #1;
    chk("rst_in_ready", 24'(in_ready2), 24'd0);
    chk("rst_out_valid", 24'(out_valid2), 24'd0);
    chk("rst_out_last", 24'(out_last2), 24'd0);
    chk("rst_sh_out", {8'h00, sh_out2}, 24'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 24'(in_ready2), 24'd1);
    chk("rel_out_valid", 24'(out_valid2), 24'd0);
    step();

    // FIPS-197 column
    set_col(32'hdb135345, 32'h8e4da1bc);
    run_col("fips");

    // output stalls
    set_col(32'hf20a225c, 32'h9fdc589d);
    stall_v[1] = 2; stall_v[2] = 2; stall_v[3] = 2;
    run_col("stall");

    // back-to-back columns, 8-cycle period
    set_col(32'hc6c6c6c6, 32'hc6c6c6c6);
    run_col("c6");
    c1 = first_acc;
    set_col(32'h01010101, 32'h01010101);
    run_col("b2b01");
    chk("period", 24'(first_acc - c1), 24'd8);

    // input gaps
    set_col(32'hd4d4d4d5, 32'hd5d5d7d6);
    gap_v[1] = 2; gap_v[2] = 1; gap_v[3] = 3;
    run_col("gaps");

    // reset after two accepted bytes
    set_in(1'b1, 24'(make_shares(8'h5a)));
    step();
    set_in(1'b1, 24'(make_shares(8'ha5)));
    step();
    set_in(1'b0, '0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 24'(in_ready2), 24'd0);
    chk("midrst_out_valid", 24'(out_valid2), 24'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_rel_in_ready", 24'(in_ready2), 24'd1);
    step();
    set_col(32'h01010101, 32'h01010101);
    run_col("after_rst");

    // random columns against the model
    for (int n = 0; n < 12; n++) begin
      set_col($urandom, 32'h0);
      chk_const = 1'b0;
      for (int k = 0; k < 4; k++) begin
        gap_v[k] = $urandom_range(0, 2);
        stall_v[k] = $urandom_range(0, 2);
      end
      run_col("rand_d2");
    end

    // d=3: re-sharing of the FIPS column
    sel = 1;
    for (int n = 0; n < 100; n++) begin
      set_col(32'hdb135345, 32'h8e4da1bc);
      if (n % 4 == 1) stall_v[n % 4] = 1;
      run_col("fips_d3");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/msk_mixcol_serial.md
# msk_mixcol_serial

Masked forward AES MixColumns unit, byte-serial, for the 32-bit HPC encryption datapath; it is the forward counterpart of the masked inverse-MixColumns constant-product block. It accepts one d-share masked column byte per handshake (rows 0..3), holds the column share-wise, then emits the four MixColumns output bytes (rows 0..3) through a valid/ready handshake. All arithmetic is GF(2^8)-linear and applied independently per share, so shares are never combined.

## Interface
- `d`, default 2: masking order, the number of shares per bit.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `sh_in` holds a valid column byte.
- `in_ready` out 1: block accepts an input byte.
- `sh_in` in 8*d: masked input byte, bit-major layout; bit i, share j at index i*d+j.
- `out_valid` out 1: `sh_out` holds a valid output byte.
- `out_ready` in 1: downstream accepts the output byte.
- `sh_out` out 8*d: masked output byte, same layout as `sh_in`.
- `out_last` out 1: high with `out_valid` on row 3.

## Operation
- Two states:
  - LOAD: `in_ready`=1, `out_valid`=0.
  - EMIT: `in_ready`=0, `out_valid`=1.
- 2-bit row counter `cnt`.
- LOAD:
  - On each `in_valid & in_ready`, store `sh_in` into column register `a[cnt]` for every share, then increment `cnt`.
  - On the accept with `cnt`=3, go to EMIT with `cnt`=0.
- EMIT:
  - Compute per share s: `b_k = xt(a_k) ^ xt(a_{k+1}) ^ a_{k+1} ^ a_{k+2} ^ a_{k+3}`, with indices mod 4 and k=`cnt`.
  - `xt(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0)`.
- `sh_out` is `b_cnt` repacked into bit-major layout. It is driven from registers only: combinational logic over `a` and `cnt`, with no input feedthrough.
- On each `out_valid & out_ready`, increment `cnt`. After the row-3 transfer, return to LOAD with `cnt`=0.
- Boundary conditions:
  - No overlap between columns: an input offered during EMIT is stalled.
  - `in_valid` low in LOAD holds state and `cnt`.
  - `out_ready` low in EMIT holds `sh_out` stable.
  - `cnt` wraps 3→0 only on the state change.
  - Reset mid-column discards any partially loaded or partially emitted column.

## Timing
- Reset values:
  - state LOAD, `cnt` 0, all `a` registers 0.
  - `in_ready` is 0 while `rst` is high and 1 after release.
  - `out_valid` 0, `out_last` 0, `sh_out` all-zero.
- First output is valid in the cycle after the 4th input accept: 1-cycle latency from last input to first output.
- Minimum column period is 8 cycles (4 load + 4 emit) with `in_valid` and `out_ready` held high.
- `in_ready`, `out_valid` and `out_last` are decoded from registered state only. None depends combinationally on `in_valid` or `out_ready`.

## Structure
- Shared header holds:
  - `AES_POLY` = 8'h1b.
  - State encodings LOAD=1'b0, EMIT=1'b1.
- One sub-module, `msk_mixcol_byte` (parameter d), purely combinational and share-wise.
  - Inputs: four d-share bytes x0..x3.
  - Output: d-share byte `2·x0 ^ 3·x1 ^ x2 ^ x3`.
  - The top instantiates it once, with inputs muxed by `cnt`.
- Annotate ports for the formal flow: sharing ports with latency 0 and count 8, using the same property style as the existing masked linear blocks.

## Test plan
- FIPS column db,13,53,45 (d=2, share0 random, share1 = value^share0), `out_ready`=1 → unmasked outputs 8e,4d,a1,bc; `out_last` on bc; first `out_valid` 1 cycle after the 4th accept.
- Column f2,0a,22,5c with `out_ready` toggled 1,0,0,1,… → outputs 9f,dc,58,9d; `sh_out` stable during stalls; `in_ready`=0 throughout EMIT.
- Columns c6,c6,c6,c6 then 01,01,01,01 back-to-back → c6×4 then 01×4; 8-cycle period per column.
- Column d4,d4,d4,d5 with gaps in `in_valid` → d5,d5,d7,d6; `cnt` holds during gaps.
- Assert `rst` after 2 accepted bytes → `in_ready` and `out_valid` immediately 0. After release, a fresh column 01,01,01,01 yields 01×4, with no residue from the aborted column.
- d=3, random re-sharing of db,13,53,45 over 100 iterations → recombined outputs always 8e,4d,a1,bc. Each output share depends only on the same-index input shares.
